// File: rtl/nock_mem.sv
// nock_mem: single-port noun memory with valid/ready requests, per-bit masked writes,
// a registered read response with backpressure, and a post-reset clearing sweep.
module nock_mem #(
   parameter int                    DATA_WIDTH = 69,
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DEPTH      = 1024,
   parameter int                    INIT_SWEEP = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  init_done
);

   localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [DATA_WIDTH-1:0] ALL_ONES  = '1;

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    init_done_q, init_done_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    addr_in_range;
   logic                    req_fire;
   logic [IDX_W-1:0]        req_idx;
   logic                    wr_en;
   logic [IDX_W-1:0]        wr_idx;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH-1:0]   wr_mask;

   // A stalled response blocks every request, so the held response can never be overwritten.
   assign req_ready     = !reset && (state_q == ST_RUN) && !(rsp_valid_q && !rsp_ready);
   assign req_fire      = req_valid && req_ready;
   assign addr_in_range = ({1'b0, req_addr} < DEPTH_W);
   assign req_idx       = req_addr[IDX_W-1:0];

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign init_done = init_done_q;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      wr_en       = 1'b0;
      wr_idx      = req_idx;
      wr_data     = req_wdata;
      wr_mask     = req_wmask;

      case (state_q)
         ST_INIT: begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q[IDX_W-1:0];
            wr_data = INIT_VALUE;
            wr_mask = ALL_ONES;
            if (cnt_q == LAST_ADDR) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
            end
            if (req_fire) begin
               if (req_we) begin
                  // Out-of-range writes are dropped rather than aliased onto a real cell.
                  wr_en = addr_in_range;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = addr_in_range ? mem_q[req_idx] : '0;
                  rsp_err_d   = !addr_in_range;
               end
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= (INIT_SWEEP != 0) ? ST_INIT : ST_RUN;
         cnt_q       <= '0;
         init_done_q <= (INIT_SWEEP == 0);
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // NOTE: the storage array has no reset; the sweep clears it, which keeps it mappable onto RAM.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < DATA_WIDTH; i++) begin
            if (wr_mask[i]) begin
               mem_q[wr_idx][i] <= wr_data[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_nock_mem.sv
// tb_nock_mem: directed checks of sweep, masked writes, out-of-range flags,
// response backpressure and mid-operation reset on three nock_mem configurations.
module tb_nock_mem;

   localparam logic [68:0] INIT_A = 69'h1_0000_0000_0000_0005;
   localparam logic [68:0] ONES   = 69'h1F_FFFF_FFFF_FFFF_FFFF;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [4:0]  req_addr;
   logic [68:0] req_wdata;
   logic [68:0] req_wmask;
   logic        rsp_ready;
   int          sel;

   logic        o_ready [3];
   logic        o_valid [3];
   logic [68:0] o_data  [3];
   logic        o_err   [3];
   logic        o_done  [3];

   int checks = 0;
   int errors = 0;

   // Instance 0: DEPTH 16 with spare address bit; 1: zero-value sweep; 2: non-power-of-two depth.
   nock_mem #(.DATA_WIDTH(69), .ADDR_WIDTH(5), .DEPTH(16), .INIT_SWEEP(1), .INIT_VALUE(INIT_A)) dut_a (
      .clock(clock), .reset(reset),
      .req_valid(req_valid && sel == 0), .req_ready(o_ready[0]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(o_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(o_data[0]),
      .rsp_err(o_err[0]), .init_done(o_done[0])
   );

   nock_mem #(.DATA_WIDTH(69), .ADDR_WIDTH(4), .DEPTH(16), .INIT_SWEEP(1), .INIT_VALUE(69'h0)) dut_b (
      .clock(clock), .reset(reset),
      .req_valid(req_valid && sel == 1), .req_ready(o_ready[1]), .req_we(req_we),
      .req_addr(req_addr[3:0]), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(o_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(o_data[1]),
      .rsp_err(o_err[1]), .init_done(o_done[1])
   );

   nock_mem #(.DATA_WIDTH(69), .ADDR_WIDTH(4), .DEPTH(12), .INIT_SWEEP(1), .INIT_VALUE(69'h0)) dut_c (
      .clock(clock), .reset(reset),
      .req_valid(req_valid && sel == 2), .req_ready(o_ready[2]), .req_we(req_we),
      .req_addr(req_addr[3:0]), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(o_valid[2]), .rsp_ready(rsp_ready), .rsp_rdata(o_data[2]),
      .rsp_err(o_err[2]), .init_done(o_done[2])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [68:0] garb(input int i);
      return {5'(i), 32'hDEAD_BEEF, 32'(i * 7 + 3)};
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic release_and_sweep(input int depth);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      check("sweep_start", {o_done[sel], o_ready[sel]}, 69'd0);
      for (int i = 1; i <= depth; i++) begin
         cyc();
         check($sformatf("sweep_cyc%0d", i), {o_done[sel], o_ready[sel]},
               (i == depth) ? 69'd3 : 69'd0);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [68:0] d, input logic [68:0] m);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = a;
      req_wdata = d;
      req_wmask = m;
      cyc();
      req_valid = 1'b0;
      req_we    = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [68:0] exp_d, input logic exp_e);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = a;
      cyc();
      req_valid = 1'b0;
      check({tag, "_valid"}, o_valid[sel], 69'd1);
      check({tag, "_data"},  o_data[sel],  exp_d);
      check({tag, "_err"},   o_err[sel],   exp_e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;
      rsp_ready = 1'b1;
      sel       = 0;
      repeat (3) cyc();

      check("rst_valid", o_valid[0], 69'd0);
      check("rst_data",  o_data[0],  69'd0);
      check("rst_err",   o_err[0],   69'd0);
      check("rst_done",  o_done[0],  69'd0);
      check("rst_ready", o_ready[0], 69'd0);

      release_and_sweep(16);

      // Fill with garbage, then reset again: the second sweep must clear it.
      for (int i = 0; i < 16; i++) wr(5'(i), garb(i), ONES);
      rd("garbage5", 5'd5, garb(5), 1'b0);
      release_and_sweep(16);
      for (int i = 0; i < 16; i++) rd($sformatf("sweep_a%0d", i), 5'(i), INIT_A, 1'b0);

      sel = 1;
      for (int i = 0; i < 16; i++) rd($sformatf("sweep_b%0d", i), 5'(i), 69'd0, 1'b0);

      sel = 0;
      wr(5'd3, ONES, ONES);
      wr(5'd3, 69'd0, 69'h0_0000_0000_FFFF_FFFF);
      rd("masked3", 5'd3, 69'h1F_FFFF_FFFF_0000_0000, 1'b0);
      wr(5'd4, ONES, 69'd0);
      rd("zeromask4", 5'd4, INIT_A, 1'b0);
      wr(5'd7, garb(7), ONES);
      rd("raw7", 5'd7, garb(7), 1'b0);
      wr(5'd20, garb(20), ONES);
      rd("oor_a20", 5'd20, 69'd0, 1'b1);
      rd("alias_a4", 5'd4, INIT_A, 1'b0);

      sel = 2;
      wr(5'd13, 69'h5, ONES);
      rd("oor_c13", 5'd13, 69'd0, 1'b1);
      for (int i = 0; i < 12; i++) rd($sformatf("keep_c%0d", i), 5'(i), 69'd0, 1'b0);

      // Streaming reads of 0,1,2 with a three-cycle stall after the first response.
      sel = 0;
      wr(5'd0, garb(100), ONES);
      wr(5'd1, garb(101), ONES);
      wr(5'd2, garb(102), ONES);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 5'd0;
      cyc();
      rsp_ready = 1'b0;
      req_addr  = 5'd1;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("stall%0d_valid", k), o_valid[0], 69'd1);
         check($sformatf("stall%0d_data", k),  o_data[0],  garb(100));
         check($sformatf("stall%0d_ready", k), o_ready[0], 69'd0);
         cyc();
      end
      rsp_ready = 1'b1;
      #1;
      check("resume_ready", o_ready[0], 69'd1);
      check("resume_data",  o_data[0],  garb(100));
      cyc();
      req_addr = 5'd2;
      check("stream1_valid", o_valid[0], 69'd1);
      check("stream1_data",  o_data[0],  garb(101));
      cyc();
      req_valid = 1'b0;
      check("stream2_valid", o_valid[0], 69'd1);
      check("stream2_data",  o_data[0],  garb(102));
      cyc();
      check("stream_end_valid", o_valid[0], 69'd0);

      // Reset during the sweep restarts it from address 0.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      repeat (7) cyc();
      check("midsweep_done", o_done[0], 69'd0);
      release_and_sweep(16);

      // Reset while a response is stalled drops rsp_valid without waiting for a clock.
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 5'd1;
      cyc();
      req_valid = 1'b0;
      check("stalled_valid", o_valid[0], 69'd1);
      reset = 1'b1;
      #1;
      check("rst_async_drop", o_valid[0], 69'd0);
      rsp_ready = 1'b1;
      release_and_sweep(16);
      rd("post_reset_a1", 5'd1, INIT_A, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
